// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX->MEM pipeline stage with valid/ready flow control, flush and stall counter
//
// Purpose:
//   Holds the instruction travelling from EX to MEM. MEM can back-pressure EX
//   through out_ready. flush squashes every held entry. stall_cycles counts the
//   cycles in which MEM refuses a valid entry, and saturates at its maximum.
//
// Configuration macro: EX_MEM_SKID_EN
//   undefined : single entry, in_ready = ~out_valid | out_ready (combinational)
//   defined   : main entry plus one skid entry, in_ready = ~skid_valid (flop only)
//
// Ports:
//   clk, reset                  clock (rising edge), asynchronous active-high reset
//   flush                       squash all held entries
//   in_valid / in_ready         EX-side handshake
//   ex_*                        control bits and payload from EX
//   out_valid / out_ready       MEM-side handshake
//   mem_reg_write .. mem_branch registered control, gated by out_valid
//   mem_pc .. mem_rd            registered payload
//   stall_cycles                saturating count of out_valid & ~out_ready cycles
module ex_mem_stage #(
  parameter int PC_WIDTH      = 12,
  parameter int DATA_WIDTH    = 16,
  parameter int REGADDR_WIDTH = 3,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     ex_reg_write,
  input  logic                     ex_mem_read,
  input  logic                     ex_mem_write,
  input  logic                     ex_branch,
  input  logic [PC_WIDTH-1:0]      ex_pc,
  input  logic [DATA_WIDTH-1:0]    ex_alu_result,
  input  logic [DATA_WIDTH-1:0]    ex_read_data2,
  input  logic [REGADDR_WIDTH-1:0] ex_rd,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     mem_reg_write,
  output logic                     mem_mem_read,
  output logic                     mem_mem_write,
  output logic                     mem_branch,
  output logic [PC_WIDTH-1:0]      mem_pc,
  output logic [DATA_WIDTH-1:0]    mem_alu_result,
  output logic [DATA_WIDTH-1:0]    mem_write_data,
  output logic [REGADDR_WIDTH-1:0] mem_rd,
  output logic [CNT_WIDTH-1:0]     stall_cycles
);

  // Control bits and payload travel together as one flat word.
  localparam int PW = 4 + PC_WIDTH + 2 * DATA_WIDTH + REGADDR_WIDTH;

  logic [PW-1:0] in_pay;
  assign in_pay = {ex_reg_write, ex_mem_read, ex_mem_write, ex_branch,
                   ex_pc, ex_alu_result, ex_read_data2, ex_rd};

  logic          main_valid_q, main_valid_d;
  logic [PW-1:0] main_q, main_d;
  logic          accept, consume;

  assign accept  = in_valid & in_ready;
  assign consume = main_valid_q & out_ready;

`ifdef EX_MEM_SKID_EN
  logic          skid_valid_q, skid_valid_d;
  logic [PW-1:0] skid_q, skid_d;

  // Registered ready: EX only ever sees the skid flop, never out_ready.
  assign in_ready = ~skid_valid_q;

  always_comb begin
    main_valid_d = main_valid_q;
    main_d       = main_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // Stage is full and in_ready is low, so no accept can happen here.
      if (consume) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end
    end else if (!main_valid_q || consume) begin
      main_valid_d = accept;
      if (accept) begin
        main_d = in_pay;
      end
    end else if (accept) begin
      // Main is held by MEM: park the newcomer behind it.
      skid_valid_d = 1'b1;
      skid_d       = in_pay;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
    end
  end
`else
  assign in_ready = ~main_valid_q | out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_d       = main_q;
    if (flush) begin
      main_valid_d = 1'b0;
    end else if (accept) begin
      // Covers accept-with-consume too: the new entry replaces the old, no bubble.
      main_valid_d = 1'b1;
      main_d       = in_pay;
    end else if (consume) begin
      main_valid_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      main_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_q       <= main_d;
    end
  end

  // Stall counter: counts refused valid cycles, including a cycle that flushes.
  logic [CNT_WIDTH-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (main_valid_q && !out_ready && (stall_q != {CNT_WIDTH{1'b1}})) begin
      stall_d = stall_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  logic [3:0] ctl_q;
  assign {ctl_q, mem_pc, mem_alu_result, mem_write_data, mem_rd} = main_q;

  // An invalid entry must never write memory or the register file.
  assign mem_reg_write = ctl_q[3] & main_valid_q;
  assign mem_mem_read  = ctl_q[2] & main_valid_q;
  assign mem_mem_write = ctl_q[1] & main_valid_q;
  assign mem_branch    = ctl_q[0] & main_valid_q;

  assign out_valid    = main_valid_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - randomized self-checking bench for ex_mem_stage against a FIFO model
module tb_ex_mem_stage;
  localparam int PW   = 12;
  localparam int DW   = 16;
  localparam int RW   = 3;
  localparam int CW   = 4;
  localparam int CMAX = 15;
`ifdef EX_MEM_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  typedef struct packed {
    logic [3:0]    ctl;   // {reg_write, mem_read, mem_write, branch}
    logic [PW-1:0] pc;
    logic [DW-1:0] alu;
    logic [DW-1:0] wd;
    logic [RW-1:0] rd;
  } ent_t;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic          ex_reg_write, ex_mem_read, ex_mem_write, ex_branch;
  logic [PW-1:0] ex_pc;
  logic [DW-1:0] ex_alu_result, ex_read_data2;
  logic [RW-1:0] ex_rd;
  logic          mem_reg_write, mem_mem_read, mem_mem_write, mem_branch;
  logic [PW-1:0] mem_pc;
  logic [DW-1:0] mem_alu_result, mem_write_data;
  logic [RW-1:0] mem_rd;
  logic [CW-1:0] stall_cycles;

  ex_mem_stage #(.PC_WIDTH(PW), .DATA_WIDTH(DW), .REGADDR_WIDTH(RW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
    .ex_pc(ex_pc), .ex_alu_result(ex_alu_result),
    .ex_read_data2(ex_read_data2), .ex_rd(ex_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .mem_branch(mem_branch),
    .mem_pc(mem_pc), .mem_alu_result(mem_alu_result),
    .mem_write_data(mem_write_data), .mem_rd(mem_rd),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // Behavioural model: an ordered queue of in-flight instructions plus a counter.
  ent_t q[$];
  int   mcnt;
  int   vectors = 0;
  int   errors  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_ready();
    if (CAP == 1) return (q.size() == 0) || out_ready;
    return q.size() < 2;
  endfunction

  task automatic drive(input bit iv, input bit ordy, input bit fl, input ent_t e);
    in_valid      = iv;
    out_ready     = ordy;
    flush         = fl;
    ex_reg_write  = e.ctl[3];
    ex_mem_read   = e.ctl[2];
    ex_mem_write  = e.ctl[1];
    ex_branch     = e.ctl[0];
    ex_pc         = e.pc;
    ex_alu_result = e.alu;
    ex_read_data2 = e.wd;
    ex_rd         = e.rd;
  endtask

  task automatic compare_all();
    logic [3:0] ctl;
    ctl = {mem_reg_write, mem_mem_read, mem_mem_write, mem_branch};
    chk("out_valid", out_valid, q.size() > 0);
    chk("in_ready", in_ready, model_ready());
    chk("stall_cycles", stall_cycles, mcnt);
    if (q.size() > 0) begin
      chk("mem_pc", mem_pc, q[0].pc);
      chk("mem_alu_result", mem_alu_result, q[0].alu);
      chk("mem_write_data", mem_write_data, q[0].wd);
      chk("mem_rd", mem_rd, q[0].rd);
      chk("mem_ctl", ctl, q[0].ctl);
    end else begin
      chk("mem_ctl_idle", ctl, 0);
    end
  endtask

  // One clock cycle: drive, compare on the falling edge, advance the model on the rising edge.
  task automatic step(input bit iv, input bit ordy, input bit fl, input ent_t e);
    bit rdy;
    drive(iv, ordy, fl, e);
    @(negedge clk);
    compare_all();
    rdy = model_ready();
    @(posedge clk);
    if (q.size() > 0 && !ordy && mcnt < CMAX) mcnt++;
    if (fl) begin
      q.delete();
    end else begin
      if (q.size() > 0 && ordy) void'(q.pop_front());
      if (iv && rdy) q.push_back(e);
    end
    #1;
  endtask

  task automatic do_reset();
    ent_t z;
    z = '0;
    drive(1'b0, 1'b0, 1'b0, z);
    reset = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ctl", {mem_reg_write, mem_mem_read, mem_mem_write, mem_branch}, 0);
    chk("rst_pc", mem_pc, 0);
    chk("rst_alu", mem_alu_result, 0);
    chk("rst_wd", mem_write_data, 0);
    chk("rst_rd", mem_rd, 0);
    chk("rst_stall", stall_cycles, 0);
    q.delete();
    mcnt = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
  endtask

  function automatic ent_t rand_ent();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return ent_t'(r[$bits(ent_t)-1:0]);
  endfunction

  ent_t ea, eb, ez;

  initial begin
    ez = '0;
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, ez);
    mcnt = 0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Basic transfer with fixed values.
    ea = '{ctl: 4'b0010, pc: 12'h010, alu: 16'h1234, wd: 16'h00ab, rd: 3'd5};
    step(1'b1, 1'b1, 1'b0, ea);
    chk("t2_out_valid", out_valid, 1);
    chk("t2_pc", mem_pc, 12'h010);
    chk("t2_alu", mem_alu_result, 16'h1234);
    chk("t2_rd", mem_rd, 5);
    chk("t2_mem_write", mem_mem_write, 1);

    // Hold under back-pressure for 4 cycles.
    repeat (4) step(1'b0, 1'b0, 1'b0, ez);
    chk("t3_stall", stall_cycles, 4);
    chk("t3_pc_held", mem_pc, 12'h010);
    chk("t3_alu_held", mem_alu_result, 16'h1234);

    // Flush with a new instruction presented: it must be discarded.
    eb = '{ctl: 4'b1111, pc: 12'h0f0, alu: 16'hbeef, wd: 16'h5555, rd: 3'd2};
    step(1'b1, 1'b0, 1'b1, eb);
    chk("t5_out_valid", out_valid, 0);
    chk("t5_ctl", {mem_reg_write, mem_mem_read, mem_mem_write, mem_branch}, 0);
    chk("t5_stall_kept", stall_cycles, 5);
    step(1'b0, 1'b1, 1'b0, ez);
    chk("t5_no_delivery", out_valid, 0);

`ifdef EX_MEM_SKID_EN
    // Skid fill and ordered drain.
    step(1'b1, 1'b0, 1'b0, ea);
    step(1'b1, 1'b0, 1'b0, eb);
    chk("t4_in_ready_low", in_ready, 0);
    chk("t4_first_A", mem_pc, 12'h010);
    step(1'b0, 1'b1, 1'b0, ez);
    chk("t4_second_B", mem_pc, 12'h0f0);
    chk("t4_in_ready_back", in_ready, 1);
    step(1'b0, 1'b1, 1'b0, ez);
`endif

    // Reset mid-stream while an entry is held, then counter saturation.
    step(1'b1, 1'b0, 1'b0, ea);
    chk("t1_pre_valid", out_valid, 1);
    do_reset();
    step(1'b1, 1'b0, 1'b0, eb);
    repeat (20) step(1'b0, 1'b0, 1'b0, ez);
    chk("t6_saturate", stall_cycles, 15);
    chk("t6_held_pc", mem_pc, 12'h0f0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
             $urandom_range(0, 19) == 0, rand_ent());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
